booth_accum: RTL and testbench

BOOTH_ACCUM -- requirements
Module: booth_accum

---
 rtl/booth_accum.sv | 143 ++++++++++++++
 tb/tb_booth_accum.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_accum.sv
// Sequential radix-4 Booth accumulator: sums 16 pre-encoded partial products into a 64-bit signed product.
// Optional build macro BOOTH_ACCUM_EARLY_EXIT_EN finishes as soon as every remaining group is NOTHING.
module booth_accum (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [15:0] SHIFT,
    input  logic [15:0] SUB,
    input  logic [15:0] NOTHING,
    output logic [31:0] result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam int unsigned MW = 32;
    localparam int unsigned GN = 16;
    localparam int unsigned AW = 64;
    localparam int unsigned PW = MW + 2;
    localparam int unsigned IW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mcand_q, mcand_d;
    logic [GN-1:0]   shift_q, shift_d;
    logic [GN-1:0]   sub_q, sub_d;
    logic [GN-1:0]   nothing_q, nothing_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [MW-1:0]   result_q, result_d;
    logic            exc_q, exc_d;
    logic            rdy_q, rdy_d;

    logic [PW-1:0]   mag_c, pp_c;
    logic [AW-1:0]   pp_ext_c, acc_sum_c;
    logic            last_c;

    // Partial product of the current group, weighted by 4^idx and added to the accumulator
    always_comb begin
        mag_c = shift_q[idx_q] ? {mcand_q[MW-1], mcand_q, 1'b0}
                               : {{2{mcand_q[MW-1]}}, mcand_q};
        if (nothing_q[idx_q]) begin
            pp_c = '0;
        end else if (sub_q[idx_q]) begin
            pp_c = PW'(~mag_c + PW'(1));
        end else begin
            pp_c = mag_c;
        end
        pp_ext_c  = {{(AW-PW){pp_c[PW-1]}}, pp_c} << {idx_q, 1'b0};
        acc_sum_c = acc_q + pp_ext_c;
    end

`ifdef BOOTH_ACCUM_EARLY_EXIT_EN
    // Done once no group above the current one contributes anything
    always_comb begin
        last_c = 1'b1;
        for (int unsigned j = 0; j < GN; j++) begin
            if ((j > 32'(idx_q)) && !nothing_q[IW'(j)]) begin
                last_c = 1'b0;
            end
        end
    end
`else
    always_comb begin
        last_c = (idx_q == IW'(GN - 1));
    end
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        shift_d   = shift_q;
        sub_d     = sub_q;
        nothing_d = nothing_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d   = multiplicand;
                    shift_d   = SHIFT;
                    sub_d     = SUB;
                    nothing_d = NOTHING;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_sum_c;
                idx_d = idx_q + IW'(1);
                if (last_c) begin
                    state_d  = DONE;
                    result_d = acc_sum_c[MW-1:0];
                    // Product fits in 32 signed bits only if bits [63:31] are a pure sign extension
                    exc_d    = !((&acc_sum_c[AW-1:MW-1]) || !(|acc_sum_c[AW-1:MW-1]));
                    rdy_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            shift_q   <= '0;
            sub_q     <= '0;
            nothing_q <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            shift_q   <= shift_d;
            sub_q     <= sub_d;
            nothing_q <= nothing_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
        end
    end

    assign result         = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_accum.sv
// Directed bench for booth_accum: Booth-encodes multipliers, predicts the signed product and latency, scoreboards results.
module tb_booth_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [15:0] SHIFT, SUB, NOTHING;
    logic [31:0] result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    booth_accum dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .multiplicand   (multiplicand),
        .SHIFT          (SHIFT),
        .SUB            (SUB),
        .NOTHING        (NOTHING),
        .result         (result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Radix-4 Booth recoding of a signed 32-bit multiplier; hi = top contributing group (-1 if none)
    task automatic encode(input logic [31:0] b, output logic [15:0] sh, output logic [15:0] su,
                          output logic [15:0] no, output int hi);
        logic [32:0] bx;
        logic [2:0]  t;
        bx = {b, 1'b0};
        sh = '0; su = '0; no = '0; hi = -1;
        for (int g = 0; g < 16; g++) begin
            t = bx[2*g+2 -: 3];
            case (t)
                3'b000, 3'b111: no[g] = 1'b1;
                3'b011:         sh[g] = 1'b1;
                3'b100:         begin sh[g] = 1'b1; su[g] = 1'b1; end
                3'b101, 3'b110: su[g] = 1'b1;
                default:        ;
            endcase
            if (!no[g]) hi = g;
        end
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] b, input bit pulse);
        logic [15:0] sh, su, no;
        logic [63:0] p;
        int          hi;
        exp_t        e;
        encode(b, sh, su, no, hi);
        p     = {{32{m[31]}}, m} * {{32{b[31]}}, b};
        e.res = p[31:0];
        e.exc = !((&p[63:31]) || !(|p[63:31]));
`ifdef BOOTH_ACCUM_EARLY_EXIT_EN
        e.lat = (hi < 0) ? 1 : hi + 1;
`else
        e.lat = 16;
`endif
        sb.push_back(e);
        multiplicand = m; SHIFT = sh; SUB = su; NOTHING = no; start = 1'b1;
        @(posedge clock); #1;
        if (pulse) start = 1'b0;
    endtask

    // Waits for the RDY pulse; 'elapsed' is edges already seen since the start-sampling edge
    task automatic wait_rdy(input string tag, input int elapsed);
        int   cnt;
        bit   got;
        exp_t e;
        cnt = elapsed; got = 1'b0;
        while (cnt < 40 && !got) begin
            @(posedge clock); #1;
            cnt++;
            if (data_resultRDY) got = 1'b1;
        end
        check({tag, "_rdy_seen"}, 64'(got), 64'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 64'(result), 64'(e.res));
            check({tag, "_exc"}, 64'(data_exception), 64'(e.exc));
            check({tag, "_latency"}, 64'(cnt), 64'(e.lat));
            @(posedge clock); #1;
            check({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
            check({tag, "_hold"}, 64'({data_exception, result}), 64'({e.exc, e.res}));
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) pulses++;
        end
        check({tag, "_no_rdy"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [31:0] rm, rb;
        reset = 1'b1; start = 1'b0; multiplicand = '0; SHIFT = '0; SUB = '0; NOTHING = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 64'({data_resultRDY, data_exception, result}), 64'd0);
        reset = 1'b0;

        start_op(32'd7, 32'd3, 1'b1);                 wait_rdy("m7x3", 0);
        start_op(32'hFFFF_FFFB, 32'd6, 1'b1);         wait_rdy("neg5x6", 0);
        start_op(32'h0001_0000, 32'h0001_0000, 1'b1); wait_rdy("ovf_2p32", 0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_rdy("minxneg1", 0);
        start_op(32'h8000_0000, 32'd1, 1'b1);         wait_rdy("minx1", 0);
        start_op(32'h8000_0000, 32'hFFFF_FFFE, 1'b1); wait_rdy("minxneg2", 0);
        start_op(32'h1234_5678, 32'd0, 1'b1);         wait_rdy("times0", 0);
        start_op(32'hDEAD_BEEF, 32'd1, 1'b1);         wait_rdy("times1", 0);
        for (int r = 0; r < 6; r++) begin
            rm = $urandom; rb = $urandom;
            if (r == 0) rb = {1'b1, rb[30:0]};
            start_op(rm, rb, 1'b1);                   wait_rdy("random", 0);
        end

        // Start pulse and input churn mid-operation must be ignored
        start_op(32'h0000_1357, 32'h9ABC_DEF1, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1; multiplicand = 32'hFFFF_FFFF; SHIFT = '1; SUB = '1; NOTHING = '0;
        @(posedge clock); #1;
        start = 1'b0;
        wait_rdy("busy_start", 6);
        quiet("busy_start", 20);

        // Reset mid-operation aborts without a completion pulse
        start_op(32'h0001_2345, 32'h9ABC_DEF1, 1'b1);
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        check("abort_cleared", 64'({data_resultRDY, data_exception, result}), 64'd0);
        quiet("abort", 20);
        check("abort_result", 64'({data_exception, result}), 64'd0);
        start_op(32'd2, 32'd2, 1'b1);                 wait_rdy("after_abort", 0);

        // start held high: second operation begins on the first IDLE edge after DONE
        start_op(32'hFFFF_0003, 32'h8765_4321, 1'b0);
        sb.push_back(sb[sb.size()-1]);
        wait_rdy("held_first", 0);
        @(posedge clock); #1;
        start = 1'b0;
        wait_rdy("held_second", 0);
        quiet("held_end", 20);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
